// File: rtl/lfsr_checker.sv
// PRBS checker for the 8-bit Fibonacci LFSR generator: hunts, verifies, locks,
// then counts bit errors against the locally predicted sequence.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-low reset
//   I          in   serial data bit (generator feedback value)
//   VALID      in   I is sampled only when 1; otherwise all state holds
//   CLEAR      in   synchronous clear of ERR_COUNT (on a beat)
//   LOCKED     out  1 while in the locked state
//   ERR        out  one-cycle pulse per bit error detected while locked
//   ERR_COUNT  out  saturating error count
//   O          out  shift-register contents, O[0] newest bit
module lfsr_checker #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter int              LOCK_COUNT  = 16,
    parameter int              UNLOCK_ERRS = 4,
    parameter int              CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I,
    input  logic             VALID,
    input  logic             CLEAR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [WIDTH-1:0] O
);

    localparam int FW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_s;
    logic [FW-1:0]    r_fill;
    logic [7:0]       r_match;
    logic [3:0]       r_miss;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_exp;
    logic             w_hit;
    logic             w_bad;
    logic [WIDTH-1:0] w_s_in;
    logic [WIDTH-1:0] w_s_pred;
    logic [FW-1:0]    w_fill_inc;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] w_s_nx;
    logic [FW-1:0]    w_fill_nx;
    logic [7:0]       w_match_nx;
    logic [3:0]       w_miss_nx;
    logic [CNT_W-1:0] w_cnt_nx;

    assign w_exp      = ^(r_s & TAPS);
    assign w_hit      = (I == w_exp);
    assign w_s_in     = {r_s[WIDTH-2:0], I};
    // Locked mode shifts in the prediction so a bad bit never
    // corrupts the reference sequence.
    assign w_s_pred   = {r_s[WIDTH-2:0], w_exp};
    assign w_fill_inc = (r_fill == FW'(WIDTH)) ? r_fill : r_fill + FW'(1);
    assign w_bad      = VALID && (r_state == ST_LOCKED) && !w_hit;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_fill_nx  = r_fill;
        w_match_nx = r_match;
        w_miss_nx  = r_miss;
        if (VALID) begin
            case (r_state)
                ST_HUNT: begin
                    w_s_nx    = w_s_in;
                    w_fill_nx = w_fill_inc;
                    // All-zero is not a legal LFSR state; keep hunting.
                    if (w_fill_inc == FW'(WIDTH) && w_s_in != '0) begin
                        w_state_nx = ST_VERIFY;
                        w_match_nx = '0;
                    end
                end
                ST_VERIFY: begin
                    w_s_nx = w_s_in;
                    if (w_hit) begin
                        if (r_match == 8'(LOCK_COUNT - 1)) begin
                            w_state_nx = ST_LOCKED;
                            w_match_nx = '0;
                            w_miss_nx  = '0;
                        end else begin
                            w_match_nx = r_match + 8'd1;
                        end
                    end else begin
                        // S already holds the newest bits: restart count.
                        w_match_nx = '0;
                    end
                end
                ST_LOCKED: begin
                    w_s_nx = w_s_pred;
                    if (w_hit) begin
                        w_miss_nx = '0;
                    end else if (r_miss == 4'(UNLOCK_ERRS - 1)) begin
                        w_state_nx = ST_HUNT;
                        w_fill_nx  = '0;
                        w_miss_nx  = '0;
                    end else begin
                        w_miss_nx = r_miss + 4'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                    w_fill_nx  = '0;
                end
            endcase
        end
    end

    // Clear-then-count: an error on the clearing beat leaves a count of 1.
    always_comb begin
        w_cnt_nx = r_cnt;
        if (VALID && CLEAR) begin
            w_cnt_nx = w_bad ? CNT_W'(1) : '0;
        end else if (w_bad) begin
            w_cnt_nx = w_cnt_inc;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_HUNT;
            r_s      <= '0;
            r_fill   <= '0;
            r_match  <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_s      <= w_s_nx;
            r_fill   <= w_fill_nx;
            r_match  <= w_match_nx;
            r_miss   <= w_miss_nx;
            r_locked <= (w_state_nx == ST_LOCKED);
            r_err    <= w_bad;
            r_cnt    <= w_cnt_nx;
        end
    end

    assign LOCKED    = r_locked;
    assign ERR       = r_err;
    assign ERR_COUNT = r_cnt;
    assign O         = r_s;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: generator model drives the stream,
// per-cycle expectations are queued at drive time and checked after the edge.
module tb_lfsr_checker;

    logic        CLK;
    logic        RESET;
    logic        I;
    logic        VALID;
    logic        CLEAR;
    logic        LOCKED;
    logic        ERR;
    logic [15:0] ERR_COUNT;
    logic [7:0]  O;
    logic        LOCKED4;
    logic        ERR4;
    logic [3:0]  CNT4;
    logic [7:0]  O4;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        lk;
        logic        chk_lk;
        logic        err;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic [7:0]  o;
        logic        chk_o;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] g;
    int         ecnt;
    logic       fb;
    logic       bad;
    logic       v;
    logic       clr;
    int         n;

    lfsr_checker dut (
        .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .CLEAR(CLEAR),
        .LOCKED(LOCKED), .ERR(ERR), .ERR_COUNT(ERR_COUNT), .O(O)
    );

    lfsr_checker #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .CLEAR(CLEAR),
        .LOCKED(LOCKED4), .ERR(ERR4), .ERR_COUNT(CNT4), .O(O4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t",
                     tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(logic lk, logic clk_en, logic er, int cnt,
                                logic [7:0] o, logic co);
        exp_t x;
        x.lk     = lk;
        x.chk_lk = clk_en;
        x.err    = er;
        x.cnt    = 16'(cnt);
        x.cnt4   = (cnt > 15) ? 4'hF : 4'(cnt);
        x.o      = o;
        x.chk_o  = co;
        return x;
    endfunction

    // Reference generator: newest bit is the feedback value.
    function automatic logic gen_bit();
        logic f;
        f = ^(g & 8'hB8);
        g = {g[6:0], f};
        return f;
    endfunction

    task automatic drive(input logic bi, input logic vi, input logic ci,
                         input exp_t x);
        @(negedge CLK);
        I     = bi;
        VALID = vi;
        CLEAR = ci;
        sb.push_back(x);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(LOCKED), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_count"}, 32'(ERR_COUNT), 32'd0);
        chk({tag, "_o"}, 32'(O), 32'd0);
        chk({tag, "_count4"}, 32'(CNT4), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        I     = 1'b0;
        VALID = 1'b0;
        CLEAR = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_lk) chk("locked", 32'(LOCKED), 32'(e.lk));
            chk("err", 32'(ERR), 32'(e.err));
            chk("count", 32'(ERR_COUNT), 32'(e.cnt));
            chk("count4", 32'(CNT4), 32'(e.cnt4));
            if (e.chk_o) chk("o", 32'(O), 32'(e.o));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0;
        I     = 1'b0;
        VALID = 1'b0;
        CLEAR = 1'b0;

        // Clean stream: lock after beat 24, O follows generator.
        do_reset();
        g    = 8'h01;
        ecnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            fb = gen_bit();
            drive(fb, 1'b1, 1'b0, mk(k >= 24, 1'b1, 1'b0, 0, g, k >= 8));
        end

        // Single inverted bit at beat 100.
        for (int k = 1; k <= 600; k++) begin
            fb  = gen_bit();
            bad = (k == 100);
            if (bad) ecnt++;
            drive(fb ^ bad, 1'b1, 1'b0, mk(1'b1, 1'b1, bad, ecnt, g, 1'b1));
        end

        // Clear, then four consecutive errors: unlock, relock 24 beats later.
        fb   = gen_bit();
        ecnt = 0;
        drive(fb, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, g, 1'b1));
        for (int k = 1; k <= 150; k++) begin
            fb  = gen_bit();
            bad = (k >= 50 && k <= 53);
            if (bad) ecnt++;
            drive(fb ^ bad, 1'b1, 1'b0,
                  mk((k < 53) || (k >= 77), 1'b1, bad, ecnt, g, 1'b1));
        end

        // All-zero input never locks; clean stream then locks in time.
        do_reset();
        ecnt = 0;
        for (int k = 1; k <= 300; k++)
            drive(1'b0, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b1));
        g = 8'h01;
        for (int c = 1; c <= 200; c++) begin
            fb = gen_bit();
            drive(fb, 1'b1, 1'b0, mk(1'b1, c >= 28, 1'b0, 0, g, c >= 8));
        end

        // Random VALID gaps, then clear on an error beat.
        do_reset();
        g    = 8'h01;
        ecnt = 0;
        n    = 0;
        while (n < 140) begin
            v   = 1'($urandom_range(0, 1));
            bad = 1'b0;
            clr = 1'b0;
            if (v) begin
                n++;
                fb  = gen_bit();
                bad = (n == 110) || (n == 120) || (n == 130);
                clr = (n == 130);
                if (clr) ecnt = bad ? 1 : 0;
                else if (bad) ecnt++;
            end else begin
                fb = 1'($urandom_range(0, 1));
            end
            drive(fb ^ bad, v, clr, mk(n >= 24, 1'b1, bad, ecnt, g, n >= 8));
        end

        // Saturation on the narrow counter, then async reset while locked.
        do_reset();
        g    = 8'h01;
        ecnt = 0;
        for (int k = 1; k <= 130; k++) begin
            fb  = gen_bit();
            bad = (k >= 35) && (k % 5 == 0);
            if (bad) ecnt++;
            drive(fb ^ bad, 1'b1, 1'b0, mk(k >= 24, 1'b1, bad, ecnt, g, k >= 8));
        end
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        VALID = 1'b0;
        @(negedge CLK);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial pseudo-random bit-stream checker; the receiving end of the 8-bit Fibonacci LFSR generator (taps 7,5,4,3; polynomial x^8+x^6+x^5+x^4+1; period 255).
- Self-synchronises to the incoming stream, declares lock, then counts bit errors against the locally predicted sequence.
- Used at link/loopback endpoints to do BER checks on PRBS traffic from the generator.

Parameters:
- WIDTH, 8, shift-register length.
- TAPS, 8'hB8, feedback mask over S[WIDTH-1:0]; expected bit = XOR of S bits where mask=1 (0xB8 selects bits 7,5,4,3).
- LOCK_COUNT, 16, consecutive matching bits required to declare lock (1..255).
- UNLOCK_ERRS, 4, consecutive mismatches in LOCKED that force re-hunt (1..15).
- CNT_W, 16, error counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I  in  1  serial data bit; the generator's newest bit, i.e. its feedback value.
- VALID  in  1  I is sampled on this edge only when VALID=1; otherwise all state holds.
- CLEAR  in  1  synchronous clear of ERR_COUNT.
- LOCKED  out  1  registered; 1 while in LOCKED state.
- ERR  out  1  registered one-cycle pulse per detected bit error in LOCKED.
- ERR_COUNT  out  CNT_W  saturating count of errors detected in LOCKED.
- O  out  WIDTH  current shift-register contents S; O[0] is the newest bit.

Behaviour:
- Reset (RESET=0, async): S=0, fill=0, match=0, miss=0, state=HUNT, LOCKED=0, ERR=0, ERR_COUNT=0. Takes effect immediately, including mid-stream. Operation resumes on the first VALID edge after release.
- exp = ^(S & TAPS). A "beat" is a rising edge with VALID=1. Non-beat edges hold all state; ERR is 0 on every non-beat edge.
- HUNT:
  - Each beat: S<={S[W-2:0],I}; fill increments, saturating at WIDTH.
  - When fill==WIDTH and S!=0, go to VERIFY with match=0.
  - S==0 is an illegal LFSR state: stay in HUNT, keep shifting.
- VERIFY:
  - Each beat: S<={S[W-2:0],I}.
  - If I==exp, match++. Reaching LOCK_COUNT goes to LOCKED; LOCKED=1 is visible the edge of the final matching beat.
  - If I!=exp, match=0 and stay in VERIFY (self-resync, since S now holds the newest bits). No ERR, no count.
- LOCKED:
  - Each beat: S<={S[W-2:0],exp}. The predicted bit is used, so one error does not propagate.
  - I==exp: miss=0.
  - I!=exp: ERR=1 on that edge, ERR_COUNT++ (saturates at all-ones), miss++.
  - When miss reaches UNLOCK_ERRS: state=HUNT, fill=0, LOCKED=0 on the same edge. That final error is still pulsed and counted.
- CLEAR: ERR_COUNT<=0, or <=1 if an error is detected on the same beat (clear-then-count). CLEAR does not affect lock state or S.
- Latency: error visible on ERR/ERR_COUNT on the edge that samples the bad bit (1 cycle after I is presented).
- Time to lock from reset on a clean stream: WIDTH+LOCK_COUNT beats (24 by default).

Test Plan:
- Clean stream from a generator model seeded 0x01 (bit stream 0,0,0,1,1,1,0,0,...) with VALID=1 continuously -> LOCKED rises after beat 24. ERR never asserts. ERR_COUNT=0 after 1000 beats. O tracks the generator state.
- After lock, invert one bit at beat 100 -> exactly one ERR pulse on that edge, ERR_COUNT=1, LOCKED stays 1, no further errors over the next 500 beats.
- After lock, invert 4 consecutive bits -> ERR_COUNT=4, LOCKED falls on the 4th error edge. Relocks after 24 further clean beats with ERR_COUNT still 4.
- I held 0 for 300 beats -> LOCKED stays 0, ERR_COUNT=0. Then apply a clean stream -> lock within 24 beats of the first nonzero fill.
- VALID toggled randomly (about 50%) on a clean stream -> same lock point in beats, state frozen on VALID=0 edges. CLEAR asserted on an error beat -> ERR_COUNT=1.
- Build with CNT_W=4 and inject 20 isolated errors -> ERR_COUNT saturates at 15. Assert RESET low mid-stream while locked -> all outputs 0 immediately, before the next edge.
